// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and result bundle for the bit-serial ripple-borrow subtractor.
// The requester drives the operands and start; the subtractor returns status and result.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, Ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop; results are published only on entry to DONE.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_ripple_subtractor_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;

  assign a_bit  = a_sh_q[0];
  assign b_bit  = b_sh_q[0];
  assign d_bit  = a_bit ^ b_bit ^ br_q;
  assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          br_d    = bus.Bin;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        // The bit processed here is the MSB, so d_bit is the final sign bit.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = br_nxt;
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor (WIDTH=4): expected results are queued at
// start and compared when done pulses; latency, busy length and reset behaviour are checked too.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t e;
    int   r;
    int   sa;
    int   sb;
    int   sr;
    r      = a - b - bin;
    sa     = (a >= 8) ? a - 16 : a;
    sb     = (b >= 8) ? b - 16 : b;
    sr     = sa - sb - bin;
    e.diff = r[W-1:0];
    e.bout = (a < b + bin);
    e.ovf  = (sr > 7) || (sr < -8);
    return e;
  endfunction

  // Called at a negedge; leaves start asserted across one rising edge.
  task automatic start_op(input int a, input int b, input int bin);
    bus.start = 1'b1;
    bus.A     = a[W-1:0];
    bus.B     = b[W-1:0];
    bus.Bin   = bin[0];
    sb_q.push_back(model(a, b, bin));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done, then checks latency, busy length and the queued result.
  task automatic collect(input string tag, input int cyc0, input int busy0);
    int   cyc;
    int   busy_n;
    exp_t e;
    cyc    = cyc0;
    busy_n = busy0;
    while (!bus.done && cyc < 30) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_lat"}, cyc, 32'd5);
      check_val({tag, "_busycyc"}, busy_n, 32'd4);
      check_val({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_val({tag, "_diff"}, {28'd0, bus.Diff}, {28'd0, e.diff});
        check_val({tag, "_bout"}, {31'd0, bus.Bout}, {31'd0, e.bout});
        check_val({tag, "_ovf"}, {31'd0, bus.Ovf}, {31'd0, e.ovf});
      end
    end
  endtask

  initial begin
    int   b0;
    int   seen_done;
    exp_t e;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_diff", {28'd0, bus.Diff}, 32'd0);
    check_val("rst_bout", {31'd0, bus.Bout}, 32'd0);
    check_val("rst_ovf", {31'd0, bus.Ovf}, 32'd0);
    @(negedge clk);

    // Directed cases, each from IDLE, with a one-cycle done check.
    start_op(9, 3, 0);  collect("a9b3", 1, 0);
    @(negedge clk); check_val("done_pulse1", {31'd0, bus.done}, 32'd0);
    check_val("hold_diff", {28'd0, bus.Diff}, 32'd6);
    start_op(3, 9, 0);  collect("a3b9", 1, 0);
    @(negedge clk);
    start_op(0, 0, 1);  collect("a0b0c1", 1, 0);
    @(negedge clk);
    start_op(8, 1, 0);  collect("a8b1", 1, 0);
    @(negedge clk);

    // Spec example values checked as literals too.
    start_op(3, 9, 0);  collect("lit", 1, 0);
    check_val("lit_diff_A", {28'd0, bus.Diff}, 32'hA);
    @(negedge clk);

    // Start pulsed during SHIFT must be ignored.
    start_op(5, 2, 0);
    b0 = bus.busy ? 1 : 0;
    bus.start = 1'b1; bus.A = 4'hF; bus.B = 4'h0;
    @(negedge clk);
    bus.start = 1'b0;
    collect("ign", 2, b0);
    check_val("ign_diff3", {28'd0, bus.Diff}, 32'd3);
    @(negedge clk);
    check_val("ign_no_extra", {31'd0, bus.done}, 32'd0);

    // Back-to-back: start held in the DONE cycle.
    start_op(9, 3, 0);  collect("b2b_first", 1, 0);
    start_op(15, 0, 0);
    check_val("b2b_nogap", {31'd0, bus.busy}, 32'd1);
    collect("b2b_second", 1, 0);
    check_val("b2b_diffF", {28'd0, bus.Diff}, 32'hF);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts the operation.
    start_op(9, 3, 0);
    e = sb_q.pop_back();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_val("abort_diff", {28'd0, bus.Diff}, 32'd0);
    check_val("abort_bout", {31'd0, bus.Bout}, 32'd0);
    check_val("abort_ovf", {31'd0, bus.Ovf}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) seen_done = 1;
      @(negedge clk);
    end
    check_val("abort_no_done", seen_done, 32'd0);

    // rst and start together: reset wins.
    rst = 1'b1; bus.start = 1'b1; bus.A = 4'h9; bus.B = 4'h3;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check_val("rst_start_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);

    // Exhaustive sweep, back-to-back from DONE.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          start_op(a, b, c);
          collect("sweep", 1, 0);
        end
      end
    end
    @(negedge clk);
    check_val("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor computing Diff = A - B - Bin, one bit per clock, LSB first.
- It is the inverse-operation companion to the team's ripple-carry adder, for area-constrained datapaths that can tolerate multi-cycle latency.
- Operands are captured on a start handshake and processed through a single-bit full-subtractor cell with a borrow flip-flop.
- Results are presented with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; accepted only when the block is idle (see Behaviour).
- A  input  WIDTH  minuend; sampled on an accepted start.
- B  input  WIDTH  subtrahend; sampled on an accepted start.
- Bin  input  1  borrow-in; sampled on an accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; Diff, Bout and Ovf are valid from this cycle onward.
- Diff  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
- Ovf  output  1  two's-complement overflow of the signed subtraction.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - busy=0, done=0, Diff=0, Bout=0, Ovf=0.
  - Internal shift registers, borrow flip-flop and bit counter cleared.
- FSM states:
  - IDLE: wait for start.
  - SHIFT: process one bit per cycle.
  - DONE: present the result for one cycle.
- Start acceptance:
  - start is accepted when state is IDLE or DONE, which allows back-to-back operations.
  - On acceptance: load A, B into internal shift registers; load the borrow flip-flop with Bin; clear the counter; go to SHIFT.
  - start is ignored in SHIFT; the operation in flight is unaffected and its operands are not resampled.
- SHIFT, per cycle, with a = A_sh[0], b = B_sh[0], br = borrow flip-flop:
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - Shift d into the internal result register from the MSB side (LSB-first order).
  - Shift both operand registers right; increment the counter.
- Exit from SHIFT:
  - After exactly WIDTH SHIFT cycles, go to DONE.
  - On that transition, register the outputs: Diff <= result; Bout <= final borrow; Ovf <= (A[WIDTH-1] != B[WIDTH-1]) && (Diff[WIDTH-1] != A[WIDTH-1]), using the captured A and B.
- Output visibility:
  - Diff, Bout and Ovf change only on entry to DONE; partial results are never visible.
  - They hold their value until the next DONE entry or reset.
- DONE: done=1 for exactly one cycle. Next state is SHIFT if start=1, otherwise IDLE.
- busy=1 exactly during SHIFT cycles.
- Latency:
  - start accepted at edge N; busy high for edges N+1..N+WIDTH.
  - done high in the cycle following edge N+WIDTH, i.e. WIDTH+1 cycles after start.
  - Throughput is one result per WIDTH+1 cycles.
- Reset mid-operation: aborts immediately, no done pulse is produced, and outputs return to 0.
- start and rst asserted together: rst wins.
- Counter width is clog2(WIDTH)+1; it must not wrap before reaching WIDTH.

Test Plan:
- WIDTH=4; A=9, B=3, Bin=0, start for 1 cycle -> busy high 4 cycles; done pulse 5 cycles after start; Diff=6, Bout=0, Ovf=0.
- A=3, B=9, Bin=0 -> Diff=0xA, Bout=1, Ovf=1 (signed 3-(-7)=10 overflows).
- A=0, B=0, Bin=1 -> Diff=0xF, Bout=1, Ovf=0.
- A=8, B=1, Bin=0 -> Diff=7, Bout=0, Ovf=1.
- A=5, B=2 started, then start pulsed with A=0xF, B=0 during SHIFT -> ignored; Diff=3.
- start with A=0xF, B=0 held during the DONE cycle -> second op begins with no idle gap; Diff=0xF.
- rst asserted at 2nd SHIFT cycle -> busy=0 next cycle; no done pulse; Diff=0, Bout=0, Ovf=0.
- Exhaustive sweep of A, B, Bin against a reference model -> all results match.
